// File: rtl/maze_renderer.sv
// ---------------------------------------------------------------------------
// maze_renderer
// Renders a cell maze with a player marker and a goal marker onto the
// 96x64 RGB565 OLED pixel path, and owns the player state (position, move
// counter, win flag). Buttons move the player one cell per rising edge;
// walls and the maze border block moves.
//
// Ports
//   clk                  system clock
//   reset                synchronous, active-high reset
//   index                pixel index from the OLED driver (x = index % WIDTH)
//   btn_u/d/l/r          debounced button levels
//   restart              level; returns the player to the start cell
//   data                 RGB565 colour of the pixel at index (2-cycle latency)
//   player_x, player_y   current player cell
//   moves                accepted moves, saturating at 255
//   win                  high once the player has reached the goal
// ---------------------------------------------------------------------------
module maze_renderer #(
    parameter int                     WIDTH      = 96,
    parameter int                     HEIGHT     = 64,
    parameter int                     CELL       = 12,
    parameter int                     WALL       = 3,
    parameter int                     COLS       = 7,
    parameter int                     ROWS       = 5,
    parameter logic [2*COLS*ROWS-1:0] MAZE       = '0,
    parameter int                     START_X    = 0,
    parameter int                     START_Y    = 0,
    parameter int                     GOAL_X     = 6,
    parameter int                     GOAL_Y     = 4,
    parameter logic [15:0]            WALL_COL   = 16'hFFFF,
    parameter logic [15:0]            PLAYER_COL = 16'h001F,
    parameter logic [15:0]            GOAL_COL   = 16'h07E0,
    parameter logic [15:0]            BG_COL     = 16'h0000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(WIDTH*HEIGHT)-1:0]  index,
    input  logic                             btn_u,
    input  logic                             btn_d,
    input  logic                             btn_l,
    input  logic                             btn_r,
    input  logic                             restart,
    output logic [15:0]                      data,
    output logic [$clog2(COLS)-1:0]          player_x,
    output logic [$clog2(ROWS)-1:0]          player_y,
    output logic [7:0]                       moves,
    output logic                             win
);

    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT);
    localparam int PXW = $clog2(COLS);
    localparam int PYW = $clog2(ROWS);

    // Wall lookups; cells outside the maze report no wall so callers may
    // pass cx-1 / cy-1 without guarding.
    function automatic logic east_wall(input int cx, input int cy);
        logic [2*COLS*ROWS-1:0] sh;
        if (cx < 0 || cy < 0 || cx >= COLS || cy >= ROWS) return 1'b0;
        sh = MAZE >> (2 * (cy * COLS + cx));
        return sh[0];
    endfunction

    function automatic logic south_wall(input int cx, input int cy);
        logic [2*COLS*ROWS-1:0] sh;
        if (cx < 0 || cy < 0 || cx >= COLS || cy >= ROWS) return 1'b0;
        sh = MAZE >> (2 * (cy * COLS + cx) + 1);
        return sh[0];
    endfunction

    // ---------------- Pixel pipeline, stage 1: coordinates -----------------
    logic [XW-1:0] x_d, cx_d, lx_d, x_q, cx_q, lx_q;
    logic [YW-1:0] y_d, cy_d, ly_d, y_q, cy_q, ly_q;
    logic          oor_d, oor_q;
    logic          vld_q;   // keeps data at 0 for the cycle after reset

    assign x_d   = XW'(int'(index) % WIDTH);
    assign y_d   = YW'(int'(index) / WIDTH);
    assign oor_d = int'(index) >= WIDTH * HEIGHT;
    assign cx_d  = XW'(int'(x_d) / CELL);
    assign lx_d  = XW'(int'(x_d) % CELL);
    assign cy_d  = YW'(int'(y_d) / CELL);
    assign ly_d  = YW'(int'(y_d) % CELL);

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            cx_q  <= '0;
            lx_q  <= '0;
            cy_q  <= '0;
            ly_q  <= '0;
            oor_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            cx_q  <= cx_d;
            lx_q  <= lx_d;
            cy_q  <= cy_d;
            ly_q  <= ly_d;
            oor_q <= oor_d;
            vld_q <= 1'b1;
        end
    end

    // ---------------- Pixel pipeline, stage 2: colour ----------------------
    logic [15:0]    data_d, data_q;
    logic [PXW-1:0] px_q, px_d;
    logic [PYW-1:0] py_q, py_d;

    always_comb begin
        data_d = BG_COL;
        if (!vld_q || oor_q)
            data_d = 16'h0000;
        else if (int'(x_q) >= COLS * CELL || int'(y_q) >= ROWS * CELL)
            data_d = WALL_COL;
        else if (int'(lx_q) < WALL && int'(ly_q) < WALL)
            data_d = WALL_COL;
        else if (int'(lx_q) < WALL &&
                 (cx_q == '0 || east_wall(int'(cx_q) - 1, int'(cy_q))))
            data_d = WALL_COL;
        else if (int'(ly_q) < WALL &&
                 (cy_q == '0 || south_wall(int'(cx_q), int'(cy_q) - 1)))
            data_d = WALL_COL;
        else if (int'(cx_q) == int'(px_q) && int'(cy_q) == int'(py_q))
            data_d = PLAYER_COL;
        else if (int'(cx_q) == GOAL_X && int'(cy_q) == GOAL_Y)
            data_d = GOAL_COL;
    end

    always_ff @(posedge clk) begin
        if (reset) data_q <= 16'h0000;
        else       data_q <= data_d;
    end

    assign data = data_q;

    // ---------------- Buttons and player state -----------------------------
    typedef enum logic [0:0] {S_PLAY, S_WON} state_t;

    state_t     state_q, state_d;
    logic [3:0] btn_vec;             // {u, d, l, r}
    logic [3:0] prev_q;
    logic [3:0] edge_d, edge_q;
    logic [7:0] moves_q, moves_d;
    int         tx_c, ty_c;
    logic       blocked_c;

    assign btn_vec = {btn_u, btn_d, btn_l, btn_r};
    // Edges seen while restart is high are dropped rather than deferred.
    assign edge_d  = btn_vec & ~prev_q & {4{~restart}};

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 4'hF;         // a button held through reset is not an edge
            edge_q  <= 4'h0;
            state_q <= S_PLAY;
            px_q    <= PXW'(START_X);
            py_q    <= PYW'(START_Y);
            moves_q <= 8'd0;
        end else begin
            prev_q  <= btn_vec;
            edge_q  <= edge_d;
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            moves_q <= moves_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        moves_d   = moves_q;
        tx_c      = int'(px_q);
        ty_c      = int'(py_q);
        blocked_c = 1'b1;

        // Highest-priority edge wins; lower ones are simply discarded.
        if (edge_q[3]) begin
            ty_c      = int'(py_q) - 1;
            blocked_c = (py_q == '0) || south_wall(int'(px_q), int'(py_q) - 1);
        end else if (edge_q[2]) begin
            ty_c      = int'(py_q) + 1;
            blocked_c = (int'(py_q) == ROWS - 1) || south_wall(int'(px_q), int'(py_q));
        end else if (edge_q[1]) begin
            tx_c      = int'(px_q) - 1;
            blocked_c = (px_q == '0) || east_wall(int'(px_q) - 1, int'(py_q));
        end else if (edge_q[0]) begin
            tx_c      = int'(px_q) + 1;
            blocked_c = (int'(px_q) == COLS - 1) || east_wall(int'(px_q), int'(py_q));
        end

        if (restart) begin
            state_d = S_PLAY;
            px_d    = PXW'(START_X);
            py_d    = PYW'(START_Y);
            moves_d = 8'd0;
        end else if (state_q == S_PLAY && !blocked_c) begin
            px_d    = PXW'(tx_c);
            py_d    = PYW'(ty_c);
            moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
            if (tx_c == GOAL_X && ty_c == GOAL_Y) state_d = S_WON;
        end
    end

    assign player_x = px_q;
    assign player_y = py_q;
    assign moves    = moves_q;
    assign win      = (state_q == S_WON);

endmodule

// File: tb/tb_maze_renderer.sv
module tb_maze_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] index;
    logic        btn_u, btn_d, btn_l, btn_r, restart;

    // Open maze instance
    logic [15:0] data_a;
    logic [2:0]  px_a, py_a;
    logic [7:0]  moves_a;
    logic        win_a;

    // Instance with an east wall on cell (1,0)
    logic [15:0] data_w;
    logic [2:0]  px_w, py_w;
    logic [7:0]  moves_w;
    logic        win_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    maze_renderer dut (
        .clk(clk), .reset(reset), .index(index),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .restart(restart), .data(data_a), .player_x(px_a), .player_y(py_a),
        .moves(moves_a), .win(win_a)
    );

    maze_renderer #(.MAZE(70'h4)) dut_w (
        .clk(clk), .reset(reset), .index(index),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .restart(restart), .data(data_w), .player_x(px_w), .player_y(py_w),
        .moves(moves_w), .win(win_w)
    );

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        restart = 1'b0;
        step;
        step;
        reset = 1'b0;
        step;
    endtask

    // m = {u, d, l, r}; high for one cycle, position settles one edge later.
    task automatic pulse(input logic [3:0] m);
        {btn_u, btn_d, btn_l, btn_r} = m;
        step;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        step;
        $display("pulse %b -> pos=(%0d,%0d) moves=%0d win=%0d", m, px_a, py_a, moves_a, win_a);
    endtask

    task automatic test_reset;
        index = 13'd12;
        reset = 1'b1;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        restart = 1'b0;
        step;
        step;
        n_cmp++; if (data_a !== 16'h0000) begin n_bad++; $display("FAIL rst_data got %h want 0000", data_a); end
        n_cmp++; if (px_a !== 3'd0 || py_a !== 3'd0) begin n_bad++; $display("FAIL rst_pos got (%0d,%0d) want (0,0)", px_a, py_a); end
        n_cmp++; if (moves_a !== 8'd0) begin n_bad++; $display("FAIL rst_moves got %0d want 0", moves_a); end
        n_cmp++; if (win_a !== 1'b0) begin n_bad++; $display("FAIL rst_win got %0d want 0", win_a); end
        reset = 1'b0;
        step;
        $display("reset: data=%h pos=(%0d,%0d)", data_a, px_a, py_a);
    endtask

    task automatic test_render;
        logic [12:0] idx [7];
        logic [15:0] exp [7];
        idx = '{13'd0, 13'd291, 13'd12, 13'd1940, 13'd5165, 13'd90, 13'd6144};
        exp = '{16'hFFFF, 16'h001F, 16'hFFFF, 16'h0000, 16'h07E0, 16'hFFFF, 16'h0000};
        // One new index per cycle; data for idx[k-1] appears after step k.
        for (int k = 0; k <= 7; k++) begin
            if (k < 7) index = idx[k];
            step;
            if (k >= 1) begin
                $display("render index=%0d data=%h", idx[k-1], data_a);
                n_cmp++;
                if (data_a !== exp[k-1]) begin
                    n_bad++;
                    $display("FAIL render_%0d got %h want %h", idx[k-1], data_a, exp[k-1]);
                end
            end
        end
    endtask

    task automatic test_move;
        do_reset;
        btn_r = 1'b1;
        step;
        btn_r = 1'b0;
        n_cmp++; if (px_a !== 3'd0) begin n_bad++; $display("FAIL move_latency got x=%0d want 0", px_a); end
        step;
        $display("pulse R -> pos=(%0d,%0d) moves=%0d", px_a, py_a, moves_a);
        n_cmp++; if (px_a !== 3'd1 || py_a !== 3'd0) begin n_bad++; $display("FAIL move_r got (%0d,%0d) want (1,0)", px_a, py_a); end
        n_cmp++; if (moves_a !== 8'd1) begin n_bad++; $display("FAIL move_r_cnt got %0d want 1", moves_a); end
        pulse(4'b0010);
        n_cmp++; if (px_a !== 3'd0 || moves_a !== 8'd2) begin n_bad++; $display("FAIL move_l got x=%0d moves=%0d want x=0 moves=2", px_a, moves_a); end
        pulse(4'b0010);
        n_cmp++; if (px_a !== 3'd0 || moves_a !== 8'd2) begin n_bad++; $display("FAIL move_l_border got x=%0d moves=%0d want x=0 moves=2", px_a, moves_a); end
    endtask

    task automatic test_wall;
        do_reset;
        pulse(4'b0001);
        pulse(4'b0001);
        n_cmp++; if (px_w !== 3'd1 || py_w !== 3'd0) begin n_bad++; $display("FAIL wall_pos got (%0d,%0d) want (1,0)", px_w, py_w); end
        n_cmp++; if (moves_w !== 8'd1) begin n_bad++; $display("FAIL wall_moves got %0d want 1", moves_w); end
        n_cmp++; if (px_a !== 3'd2 || moves_a !== 8'd2) begin n_bad++; $display("FAIL open_pos got x=%0d moves=%0d want x=2 moves=2", px_a, moves_a); end
        index = 13'd312;
        step;
        step;
        $display("wall index=312 walled=%h open=%h", data_w, data_a);
        n_cmp++; if (data_w !== 16'hFFFF) begin n_bad++; $display("FAIL wall_pixel got %h want FFFF", data_w); end
        n_cmp++; if (data_a !== 16'h001F) begin n_bad++; $display("FAIL open_pixel got %h want 001F", data_a); end
    endtask

    task automatic test_win;
        do_reset;
        for (int i = 0; i < 6; i++) pulse(4'b0001);
        for (int i = 0; i < 3; i++) pulse(4'b0100);
        n_cmp++; if (win_a !== 1'b0 || py_a !== 3'd3) begin n_bad++; $display("FAIL win_early got win=%0d y=%0d want win=0 y=3", win_a, py_a); end
        pulse(4'b0100);
        n_cmp++; if (win_a !== 1'b1) begin n_bad++; $display("FAIL win_set got %0d want 1", win_a); end
        n_cmp++; if (moves_a !== 8'd10 || px_a !== 3'd6 || py_a !== 3'd4) begin n_bad++; $display("FAIL win_state got (%0d,%0d) moves=%0d want (6,4) moves=10", px_a, py_a, moves_a); end
        pulse(4'b1000);
        n_cmp++; if (py_a !== 3'd4 || moves_a !== 8'd10 || win_a !== 1'b1) begin n_bad++; $display("FAIL won_ignore got y=%0d moves=%0d win=%0d want y=4 moves=10 win=1", py_a, moves_a, win_a); end
    endtask

    task automatic test_restart;
        restart = 1'b1;
        step;
        restart = 1'b0;
        $display("restart -> pos=(%0d,%0d) moves=%0d win=%0d", px_a, py_a, moves_a, win_a);
        n_cmp++; if (px_a !== 3'd0 || py_a !== 3'd0) begin n_bad++; $display("FAIL restart_pos got (%0d,%0d) want (0,0)", px_a, py_a); end
        n_cmp++; if (moves_a !== 8'd0 || win_a !== 1'b0) begin n_bad++; $display("FAIL restart_state got moves=%0d win=%0d want 0/0", moves_a, win_a); end
    endtask

    task automatic test_priority;
        do_reset;
        pulse(4'b0100);
        n_cmp++; if (px_a !== 3'd0 || py_a !== 3'd1) begin n_bad++; $display("FAIL prio_setup got (%0d,%0d) want (0,1)", px_a, py_a); end
        pulse(4'b1001);
        n_cmp++; if (px_a !== 3'd0 || py_a !== 3'd0 || moves_a !== 8'd2) begin n_bad++; $display("FAIL prio_ur got (%0d,%0d) moves=%0d want (0,0) moves=2", px_a, py_a, moves_a); end
    endtask

    task automatic test_hold_reset;
        reset = 1'b1;
        btn_r = 1'b1;
        step;
        step;
        reset = 1'b0;
        step;
        step;
        step;
        $display("held R through reset -> pos=(%0d,%0d) moves=%0d", px_a, py_a, moves_a);
        n_cmp++; if (px_a !== 3'd0 || moves_a !== 8'd0) begin n_bad++; $display("FAIL hold_reset got x=%0d moves=%0d want x=0 moves=0", px_a, moves_a); end
        btn_r = 1'b0;
        step;
    endtask

    task automatic test_reset_mid;
        do_reset;
        pulse(4'b0001);
        pulse(4'b0001);
        index = 13'd12;
        step;
        step;
        n_cmp++; if (data_a !== 16'hFFFF || px_a !== 3'd2) begin n_bad++; $display("FAIL mid_pre got data=%h x=%0d want FFFF x=2", data_a, px_a); end
        reset = 1'b1;
        step;
        n_cmp++; if (px_a !== 3'd0 || moves_a !== 8'd0 || win_a !== 1'b0) begin n_bad++; $display("FAIL mid_state got x=%0d moves=%0d win=%0d want 0/0/0", px_a, moves_a, win_a); end
        n_cmp++; if (data_a !== 16'h0000) begin n_bad++; $display("FAIL mid_data0 got %h want 0000", data_a); end
        reset = 1'b0;
        step;
        n_cmp++; if (data_a !== 16'h0000) begin n_bad++; $display("FAIL mid_data1 got %h want 0000", data_a); end
        step;
        $display("after mid reset data=%h", data_a);
        n_cmp++; if (data_a !== 16'hFFFF) begin n_bad++; $display("FAIL mid_data2 got %h want FFFF", data_a); end
    endtask

    initial begin
        reset   = 1'b1;
        index   = '0;
        restart = 1'b0;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        test_reset;
        test_render;
        test_move;
        test_wall;
        test_win;
        test_restart;
        test_priority;
        test_hold_reset;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
